// File: rtl/uart_pkg.sv
// Definitions shared by the team's UART transmitter and receiver: frame
// width, receiver state encoding and the common bit-period calculation.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  // One bit period in clocks; TX and RX must agree on this exact value.
  function automatic int bit_cycles(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a
// configurable reset value so idle-high lines come out of reset inactive.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      // NOTE: non-blocking assignments make meta->q a real two-stage pipeline;
      // blocking ones here would collapse it into a single flop.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_module.sv
// UART receiver (8N1, LSB first): mid-bit sampling of the synchronised line,
// one-entry holding register with valid/ready, active-low RTS and error pulses.
module uart_rx_module
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic                      sample_clock,
  input  logic                      reset,
  input  logic                      uart_rx,
  input  logic                      ready,
  output logic [UART_DATA_BITS-1:0] receive_output,
  output logic                      valid,
  output logic                      uart_rts,
  output logic                      framing_error,
  output logic                      overrun
);

  localparam int DIVISOR    = CLOCK_FREQ / BAUD_RATE;
  localparam int BIT_CYCLES = bit_cycles(CLOCK_FREQ, BAUD_RATE);
  localparam int HALF       = BIT_CYCLES / 2;
  localparam int CNT_W      = $clog2(BIT_CYCLES);
  localparam int IDX_W      = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  logic                      rx_s;
  rx_state_t                 state;
  logic [CNT_W-1:0]          cnt;
  logic [IDX_W-1:0]          bit_idx;
  logic [UART_DATA_BITS-1:0] shift;

  logic stop_sample;
  logic stop_good;
  logic deliver;
  logic drop;
  logic valid_next;

  sync_2ff #(
    .RESET_VALUE(1'b1)
  ) u_rx_sync (
    .clk  (sample_clock),
    .rst_n(reset),
    .d    (uart_rx),
    .q    (rx_s)
  );

  // Delivery decision for the cycle in which the stop bit is sampled.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch can be inferred.
    stop_sample = 1'b0;
    stop_good   = 1'b0;
    deliver     = 1'b0;
    drop        = 1'b0;
    valid_next  = valid;

    stop_sample = (state == STOP) && (cnt == CNT_LAST);
    stop_good   = stop_sample && rx_s;
    deliver     = stop_good && (!valid || ready);
    drop        = stop_good && valid && !ready;

    if (deliver) begin
      valid_next = 1'b1;
    end else if (valid && ready) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge sample_clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      // NOTE: the shift and holding registers are cheap flops, not RAM, so they
      // are reset to give a defined receive_output straight out of reset.
      shift          <= '0;
      receive_output <= '0;
      valid          <= 1'b0;
      uart_rts       <= 1'b0;
      framing_error  <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      valid         <= valid_next;
      uart_rts      <= valid_next;
      framing_error <= stop_sample && !rx_s;
      overrun       <= drop;
      if (deliver) begin
        receive_output <= shift;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end

        // Re-check the start bit at its midpoint so short glitches are ignored.
        START: begin
          if (cnt == CNT_MID) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              cnt     <= '0;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == CNT_LAST) begin
            shift[bit_idx] <= rx_s;
            cnt            <= '0;
            if (bit_idx == IDX_LAST) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : WAIT_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // A held-low line (break) reports one framing error, then waits here.
        WAIT_IDLE: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_module.sv
// Directed bench for uart_rx_module: frames are driven bit by bit, expected
// bytes are queued at send time and compared as the monitor captures transfers.
module tb_uart_rx_module;

  localparam int BIT     = 12;                    // 1_100_000 / 100_000 + 1
  localparam int LATENCY = 2 + 6 + 9 * BIT + 1;   // start edge -> first cycle of valid/pulse

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       uart_rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] receive_output;
  logic       valid;
  logic       uart_rts;
  logic       framing_error;
  logic       overrun;

  uart_rx_module #(
    .CLOCK_FREQ(1_100_000),
    .BAUD_RATE (100_000)
  ) dut (
    .sample_clock  (clk),
    .reset         (reset),
    .uart_rx       (uart_rx),
    .ready         (ready),
    .receive_output(receive_output),
    .valid         (valid),
    .uart_rts      (uart_rts),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records transfers, pulses and their cycle numbers at negedge.
  logic [7:0] got_q[$];
  int   rise_cyc = 0, fe_cyc = 0, ov_cyc = 0;
  int   fe_cnt = 0, ov_cnt = 0, both_cnt = 0, consec_cnt = 0;
  logic valid_d = 1'b0, fe_d = 1'b0, ov_d = 1'b0;

  always @(negedge clk) begin
    valid_d <= valid;
    fe_d    <= framing_error;
    ov_d    <= overrun;
    if (valid && !valid_d) rise_cyc <= cyc;
    if (valid && ready) got_q.push_back(receive_output);
    if (framing_error) begin
      fe_cnt <= fe_cnt + 1;
      fe_cyc <= cyc;
    end
    if (overrun) begin
      ov_cnt <= ov_cnt + 1;
      ov_cyc <= cyc;
    end
    if (framing_error && overrun) both_cnt <= both_cnt + 1;
    if ((framing_error && fe_d) || (overrun && ov_d)) consec_cnt <= consec_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  int         errors = 0;
  int         checks = 0;
  int         rd_idx = 0;
  int         tx_start_cyc = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 with the line left at the stop value.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, d, 1'b0};
    tx_start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      wait_cycles(BIT);
    end
  endtask

  task automatic sb_check(input string tag);
    logic [7:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    for (int i = 0; i < 300 && got_q.size() <= rd_idx; i++) wait_cycles(1);
    if (got_q.size() > rd_idx) begin
      check(tag, {24'h0, got_q[rd_idx]}, {24'h0, e});
      rd_idx++;
    end else begin
      check({tag, "_count"}, got_q.size(), rd_idx + 1);
    end
  endtask

  int s, fe0, ov0, n0;

  initial begin
    // Reset state
    wait_cycles(4);
    check("rst_valid", {31'h0, valid}, 0);
    check("rst_rts", {31'h0, uart_rts}, 0);
    check("rst_fe", {31'h0, framing_error}, 0);
    check("rst_ov", {31'h0, overrun}, 0);
    check("rst_data", {24'h0, receive_output}, 0);
    reset = 1'b1;
    wait_cycles(5);

    // 1: loopback frame with ready held high, latency check
    ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    s = tx_start_cyc;
    sb_check("t1_data");
    check("t1_latency", rise_cyc - s, LATENCY);
    check("t1_fe", fe_cnt, 0);
    check("t1_ov", ov_cnt, 0);
    wait_cycles(2);
    check("t1_valid_low", {31'h0, valid}, 0);

    // 2: byte held while ready=0, then a single-cycle accept
    ready = 1'b0;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    wait_cycles(5);
    check("t2_valid_held", {31'h0, valid}, 1);
    check("t2_rts_high", {31'h0, uart_rts}, 1);
    check("t2_data_held", {24'h0, receive_output}, 8'h3C);
    ready = 1'b1;
    wait_cycles(1);
    ready = 1'b0;
    check("t2_valid_fall", {31'h0, valid}, 0);
    check("t2_rts_fall", {31'h0, uart_rts}, 0);
    sb_check("t2_data");

    // 3: back-to-back bytes with ready=0 -> second is dropped with overrun
    ov0 = ov_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    s = tx_start_cyc;
    wait_cycles(3);
    check("t3_ov_count", ov_cnt - ov0, 1);
    check("t3_ov_timing", ov_cyc - s, LATENCY);
    check("t3_valid_kept", {31'h0, valid}, 1);
    check("t3_data_kept", {24'h0, receive_output}, 8'h11);
    ready = 1'b1;
    wait_cycles(20);
    check("t3_valid_drained", {31'h0, valid}, 0);
    sb_check("t3_data");
    check("t3_no_extra", got_q.size(), rd_idx);

    // 4: low stop bit then a 40-clock break -> exactly one framing error
    ready = 1'b0;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    n0 = got_q.size();
    send_frame(8'h55, 1'b0);
    s = tx_start_cyc;
    wait_cycles(40);
    check("t4_fe_count", fe_cnt - fe0, 1);
    check("t4_fe_timing", fe_cyc - s, LATENCY);
    check("t4_valid_low", {31'h0, valid}, 0);
    check("t4_ov_none", ov_cnt - ov0, 0);
    uart_rx = 1'b1;
    wait_cycles(5);
    ready = 1'b1;
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    sb_check("t4_data");

    // 5: 3-clock low glitch on an idle line
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    n0 = got_q.size();
    uart_rx = 1'b0;
    wait_cycles(3);
    uart_rx = 1'b1;
    wait_cycles(30);
    check("t5_valid_low", {31'h0, valid}, 0);
    check("t5_fe_none", fe_cnt - fe0, 0);
    check("t5_ov_none", ov_cnt - ov0, 0);
    check("t5_no_byte", got_q.size(), n0);

    // 6: asynchronous reset mid-DATA while holding a byte
    ready = 1'b0;
    send_frame(8'h5A, 1'b1);
    wait_cycles(3);
    check("t6_valid_pre", {31'h0, valid}, 1);
    uart_rx = 1'b0;
    wait_cycles(40);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_valid", {31'h0, valid}, 0);
    check("t6_rst_rts", {31'h0, uart_rts}, 0);
    check("t6_rst_data", {24'h0, receive_output}, 0);
    check("t6_rst_fe", {31'h0, framing_error}, 0);
    check("t6_rst_ov", {31'h0, overrun}, 0);
    uart_rx = 1'b1;
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(5);
    ready = 1'b1;
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    sb_check("t6_data");

    // Global invariants
    wait_cycles(5);
    check("total_bytes", got_q.size(), 5);
    check("pulse_overlap", both_cnt, 0);
    check("pulse_consecutive", consec_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_module.md
Name: uart_rx_module

Overview:
- UART receiver. Peer of the team's UART transmitter: 8 data bits, LSB first, 1 start bit, 1 stop bit, no parity.
- Synchronises the asynchronous uart_rx line and samples each bit at mid-period.
- Presents each byte through a one-entry holding register with a valid/ready handshake.
- Drives active-low RTS flow control back to the remote transmitter.

Parameters:
- CLOCK_FREQ, 50_000_000, sample_clock frequency in Hz.
- BAUD_RATE, 115_200, line rate in bits/s.
- DIVISOR (localparam), CLOCK_FREQ/BAUD_RATE. Bit period BIT_CYCLES = DIVISOR+1 clocks, matching the team's transmitter. HALF = BIT_CYCLES/2 (integer divide).

Ports:
- sample_clock  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- uart_rx  input  1  serial line, asynchronous to sample_clock, idle high.
- ready  input  1  consumer accepts data this cycle.
- receive_output  output  8  received byte, stable while valid=1.
- valid  output  1  holding register full.
- uart_rts  output  1  active low; 0 = may send.
- framing_error  output  1  one-cycle pulse when the stop bit is sampled low.
- overrun  output  1  one-cycle pulse when a byte is dropped.

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - state=IDLE; counters=0; holding register=0.
  - valid=0, framing_error=0, overrun=0, uart_rts=0.
  - Both synchroniser flops=1.
- Reset mid-frame abandons the frame with no output pulse.
- Synchroniser: 2 flops; rx_s = second flop. All decisions below use rx_s only.
- Bit counter: counter width $clog2(BIT_CYCLES); counter increments each clock while in START, DATA or STOP.
- IDLE:
  - rx_s=0 -> START, counter=0.
- START:
  - When counter==HALF-1, sample rx_s.
  - rx_s=1 -> IDLE (glitch rejected, no pulse).
  - rx_s=0 -> DATA, counter=0, bit_idx=0.
- DATA:
  - When counter==BIT_CYCLES-1, shift rx_s into shift[bit_idx] (LSB first) and set counter=0.
  - After bit_idx==7 is sampled -> STOP.
- STOP:
  - When counter==BIT_CYCLES-1, sample rx_s.
  - rx_s=1 -> deliver the byte (rules below), then IDLE.
  - rx_s=0 -> framing_error=1 for one cycle, byte discarded, then WAIT_IDLE.
- WAIT_IDLE:
  - Remain until rx_s=1, then IDLE. This absorbs a break condition with no repeated error pulses.
- Delivery, evaluated in the cycle the stop bit is sampled:
  - valid=0, or valid=1 and ready=1 in the same cycle: holding register <= shift and valid=1 from the next cycle.
  - valid=1 and ready=0: overrun=1 for one cycle; new byte dropped; old byte and valid kept.
- Handshake:
  - Transfer occurs when valid=1 and ready=1.
  - valid falls the next cycle unless a new byte is delivered in that same cycle, in which case it stays 1 with the new data.
  - ready while valid=0 has no effect.
- Latency: valid rises 1 clock after the stop-bit sample. Stop-bit sample = 2 synchroniser clocks + HALF + 9*BIT_CYCLES after the start edge on uart_rx.
- uart_rts is registered: uart_rts = valid. Asserted low while the holding register is empty.
- framing_error and overrun are registered, never asserted together, and never asserted for more than one consecutive cycle.

Decomposition:
- Shared package uart_pkg:
  - rx_state_t enum {IDLE, START, DATA, STOP, WAIT_IDLE}.
  - UART_DATA_BITS=8.
  - Helper function bit_cycles(clock_freq, baud_rate) returning CLOCK_FREQ/BAUD_RATE+1, so TX and RX share one definition.
- One sub-module: sync_2ff (parameterised reset value = 1), reusable for other asynchronous inputs.
- Everything else (FSM, counters, holding register) stays in uart_rx_module.

Test Plan (CLOCK_FREQ=1_100_000, BAUD_RATE=100_000 -> DIVISOR=11, BIT_CYCLES=12, HALF=6):
1. Drive frame 0xA5 from the team's transmitter, looped back, with ready=1 -> one valid pulse with receive_output=0xA5. Stop-bit sample 116 clocks after the start edge (2+6+108); valid in the next clock; framing_error=0, overrun=0.
2. Send 0x3C with ready held 0 -> valid=1 and uart_rts=1 persist with receive_output=0x3C. Raise ready for 1 cycle -> valid=0 and uart_rts=0 next cycle.
3. Send 0x11 then 0x22 back-to-back with ready=0 -> 0x11 retained, one overrun pulse at the 0x22 stop sample. Then ready=1 -> 0x11 delivered, no 0x22.
4. Drive a low stop bit, then hold the line low 40 clocks -> exactly one framing_error pulse, valid stays 0. Release line, send 0x7E -> 0x7E received correctly.
5. Low glitch of 3 clocks on an idle line -> return to IDLE, no valid, no error pulse.
6. Assert reset mid-DATA with valid=1 -> all outputs at reset values immediately (asynchronous). After release, a 0x81 frame is received correctly.
